mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Parametrised, iterative multiply/divide unit that owns the HI/LO register pair of the multi-cycle MIPS datapath.
- Supersedes separate fixed-width mult/div blocks, the HI/LO source muxes and the standalone hi/lo registers.
- The control unit issues one operation per start pulse, waits for done, then reads hi/lo. mthi/mtlo write paths are included.
- Signed and unsigned variants; divide-by-zero is reported for the control unit's exception handling.

Parameters:
- WIDTH, 32, operand width and width of each of hi and lo; must be even and at least 4.
- SIGNED_EN, 1, 1 = MULT/DIV signed variants supported; 0 = signed opcodes execute as unsigned.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  issue request, sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  multiplicand / dividend (register A).
- b  in  WIDTH  multiplier / divisor (register B).
- hi_we  in  1  mthi write strobe.
- lo_we  in  1  mtlo write strobe.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  high from the edge after start is accepted until the done cycle ends.
- done  out  1  one-cycle completion pulse.
- div_zero  out  1  pulses with done when a DIV/DIVU had b == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset low, any time, including mid-operation):
  - state = IDLE.
  - hi, lo, busy, done, div_zero = 0.
  - Iteration counter and working registers cleared.
  - Any in-flight operation is discarded.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start = 1 at edge t0:
  - Latch op.
  - For signed ops, latch |a| and |b| plus the sign bits.
  - Counter = WIDTH-1; busy goes high.
  - Next state is CALC, except DIV/DIVU with b == 0, which goes to DONE with the divide-by-zero flag set.
- CALC: one iteration per cycle, exactly WIDTH cycles; counter decrements and the state exits after counter == 0.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, 1 quotient bit per cycle.
- FIX: one cycle of sign correction.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the dividend's sign.
  - At the edge leaving FIX, hi/lo are written:
    - Multiply: hi = product[2W-1:W], lo = product[W-1:0].
    - Divide: lo = quotient, hi = remainder.
- DONE: done = 1 for exactly one cycle, busy still 1; then IDLE.
  - Normal latency: done is high in the cycle after edge t0+WIDTH+1, i.e. WIDTH+2 cycles after the start edge.
- Divide-by-zero: done = 1 and div_zero = 1 in the cycle after t0; hi and lo are left unchanged.
- Signed overflow case, DIV MIN / -1: lo = MIN (wraps), hi = 0. No flag is raised.
- start while busy: ignored, with no queuing. start in the DONE cycle is also ignored.
- hi_we/lo_we:
  - Honoured only when busy = 0; ignored while busy.
  - Take effect at the next edge; both may be asserted together.
  - Simultaneous start and hi_we/lo_we in IDLE: the write is performed and the operation is accepted. The result later overwrites the write.
- a, b, op need only be valid on the start edge; later changes have no effect.
- With SIGNED_EN = 0, no sign logic is generated and MULT/DIV behave as MULTU/DIVU.

Decomposition:
- Shared package mdu_pkg:
  - Op encodings OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state enum (IDLE, CALC, FIX, DONE).
  - Function computing counter width, $clog2(WIDTH).
- One sub-module, mdu_iter_step: combinational single iteration.
  - Inputs: mode, accumulator/remainder, operand.
  - Output: next accumulator/remainder and quotient bit.
  - The top level holds the FSM, counter, sign fix-up and HI/LO registers.

Test Plan (WIDTH=32, SIGNED_EN=1):
1. MULT a=0xFFFFFFFD (-3), b=7 -> busy from the next cycle; done exactly 34 cycles after the start edge; hi=0xFFFFFFFF, lo=0xFFFFFFEB; div_zero=0.
2. MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. A second start during busy is ignored and the result is unchanged.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU with the same operands -> lo=0x7FFFFFFC, hi=0x00000001.
4. Preload hi=0x1234 and lo=0x5678 via hi_we/lo_we, then DIV b=0:
   - done and div_zero high together, one cycle after the start edge.
   - hi=0x1234, lo=0x5678 unchanged.
   - busy low on the following cycle.
5. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000, no div_zero.
6. Start MULT, pulse reset low at cycle 10 -> hi, lo, busy and done are 0 immediately (asynchronously). No done pulse follows. A fresh MULT 5*6 after reset release gives lo=30, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM
// states and a counter-width helper.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } opCodeT;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } stateT;

  function automatic int counterWidth(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide.
module mdu_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               isDiv,
  input  logic [2*WIDTH-1:0] accIn,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] accOut,
  output logic               qBit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sum    = '0;
    trial  = '0;
    diff   = '0;
    accOut = '0;
    qBit   = 1'b0;
    if (!isDiv) begin
      sum    = {1'b0, accIn[2*WIDTH-1:WIDTH]} + (accIn[0] ? {1'b0, operand} : '0);
      accOut = {sum, accIn[WIDTH-1:1]};
    end else begin
      // Extra guard bit: the shifted remainder can reach 2^WIDTH.
      trial  = {accIn[2*WIDTH-1:WIDTH], accIn[WIDTH-1]};
      diff   = {1'b0, trial} - {2'b00, operand};
      qBit   = ~diff[WIDTH+1];
      accOut = {(qBit ? diff[WIDTH-1:0] : trial[WIDTH-1:0]), accIn[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning the HI/LO register pair,
// including the mthi/mtlo write paths.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = counterWidth(WIDTH);

  stateT              state, nextState;
  opCodeT             opIn, opReg;
  logic [CW-1:0]      counter;
  logic [2*WIDTH-1:0] acc, stepAcc, product;
  logic [WIDTH-1:0]   operand, absA, absB, quotient, remainder;
  logic [WIDTH-1:0]   hiReg, loReg;
  logic               aNeg, bNeg, negRes, negRem, divZeroFlag, stepQ;
  logic               isDivIn, isDivReg, divByZeroIn;

  assign opIn        = opCodeT'(op);
  assign isDivIn     = (opIn == OP_DIV) || (opIn == OP_DIVU);
  assign isDivReg    = (opReg == OP_DIV) || (opReg == OP_DIVU);
  assign divByZeroIn = isDivIn && (b == '0);

  if (SIGNED_EN) begin : gSigned
    logic signedIn;
    assign signedIn = (opIn == OP_MULT) || (opIn == OP_DIV);
    assign aNeg     = signedIn & a[WIDTH-1];
    assign bNeg     = signedIn & b[WIDTH-1];
  end else begin : gUnsigned
    assign aNeg = 1'b0;
    assign bNeg = 1'b0;
  end

  assign absA = aNeg ? -a : a;
  assign absB = bNeg ? -b : b;

  mdu_iter_step #(.WIDTH(WIDTH)) uStep (
    .isDiv  (isDivReg),
    .accIn  (acc),
    .operand(operand),
    .accOut (stepAcc),
    .qBit   (stepQ)
  );

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (start) nextState = divByZeroIn ? DONE : CALC;
      CALC: if (counter == '0) nextState = FIX;
      FIX:  nextState = DONE;
      DONE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    done     = (state == DONE);
    div_zero = (state == DONE) && divZeroFlag;
  end

  // NOTE: the working registers are plain flops, not memories, so they take
  // the async reset and an aborted operation leaves nothing behind.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opReg       <= OP_MULT;
      counter     <= '0;
      acc         <= '0;
      operand     <= '0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      divZeroFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          opReg       <= opIn;
          counter     <= CW'(WIDTH - 1);
          negRes      <= aNeg ^ bNeg;
          negRem      <= aNeg;
          divZeroFlag <= divByZeroIn;
          acc         <= {{WIDTH{1'b0}}, (isDivIn ? absA : absB)};
          operand     <= isDivIn ? absB : absA;
        end
        CALC: begin
          acc     <= {stepAcc[2*WIDTH-1:1], stepAcc[0] | stepQ};
          counter <= counter - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign product   = negRes ? -acc : acc;
  assign quotient  = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remainder = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // Software writes only land while idle; a result leaving FIX wins later.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hiReg <= '0;
      loReg <= '0;
    end else if (state == FIX) begin
      hiReg <= isDivReg ? remainder : product[2*WIDTH-1:WIDTH];
      loReg <= isDivReg ? quotient  : product[WIDTH-1:0];
    end else if (state == IDLE) begin
      if (hi_we) hiReg <= wdata;
      if (lo_we) loReg <= wdata;
    end
  end

  assign hi = hiReg;
  assign lo = loReg;

endmodule
